// File: rtl/eight_bit_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : eight_bit_full_adder (with leaf cell full_adder_cell)
// Description : Ripple-carry adder built from per-bit full-adder cells.
//               {carry, sum} = i0 + i1 + cin is captured in an output register
//               (one clock of latency) whenever in_valid is high. When in_valid
//               is low the result registers hold and out_valid drops.
// Parameters  : WIDTH     - operand/sum width (>= 2, default 8)
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               in_valid  - operands valid this cycle
//               i0, i1    - addends [WIDTH-1:0]
//               cin       - carry into bit 0
//               sum       - registered sum [WIDTH-1:0]
//               carry     - registered carry-out of the MSB cell
//               out_valid - sum/carry hold a result from an in_valid cycle
//               overflow  - registered signed overflow (ADDER_OVERFLOW_EN only)
// Build macro : ADDER_OVERFLOW_EN - adds the overflow port and its register
// Revision    : 1.0 - initial release
// ============================================================================

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module eight_bit_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
`ifdef ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             out_valid
);

    // w_c[i] is the carry into cell i; w_c[WIDTH] is the final carry-out.
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_valid;

    assign w_c[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_cell u_cell (
                .a  (i0[gi]),
                .b  (i1[gi]),
                .ci (w_c[gi]),
                .s  (w_s[gi]),
                .co (w_c[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_s;
                r_carry <= w_c[WIDTH];
            end
        end
    end

    assign sum       = r_sum;
    assign carry     = r_carry;
    assign out_valid = r_valid;

`ifdef ADDER_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eight_bit_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_eight_bit_full_adder
// Description : Self-checking bench for eight_bit_full_adder (WIDTH = 8).
//               Directed vector table, streaming/hold and asynchronous reset
//               sequences, then randomized vectors against an arithmetic
//               reference model. Overflow is checked when ADDER_OVERFLOW_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eight_bit_full_adder;

    localparam int C_W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [C_W-1:0] i0;
    logic [C_W-1:0] i1;
    logic           cin;
    logic [C_W-1:0] sum;
    logic           carry;
    logic           out_valid;
`ifdef ADDER_OVERFLOW_EN
    logic           overflow;
`endif

    int n_pass;
    int n_total;

    eight_bit_full_adder #(.WIDTH(C_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .i0        (i0),
        .i1        (i1),
        .cin       (cin),
        .sum       (sum),
        .carry     (carry),
`ifdef ADDER_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    // Reference: plain integer arithmetic, signed overflow from range test.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         output logic [7:0] es, output logic ec, output logic eo);
        int u;
        int s;
        u  = int'(a) + int'(b) + int'(ci);
        s  = int'($signed(a)) + int'($signed(b)) + int'(ci);
        es = u[7:0];
        ec = (u > 255);
        eo = (s > 127) || (s < -128);
    endtask

    task automatic check(input string name, input logic [7:0] es, input logic ec,
                         input logic ev, input logic eo);
        logic bad;
        logic ao;
        bad = (sum !== es) || (carry !== ec) || (out_valid !== ev);
        ao  = eo;
`ifdef ADDER_OVERFLOW_EN
        ao  = overflow;
        bad = bad || (overflow !== eo);
`endif
        n_total++;
        if (bad)
            $display("FAIL %s: got sum=%h carry=%b valid=%b ovf=%b, expected sum=%h carry=%b valid=%b ovf=%b",
                     name, sum, carry, out_valid, ao, es, ec, ev, eo);
        else
            n_pass++;
    endtask

    // Drive operands mid-cycle, clock them in, sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        in_valid = v;
        i0       = a;
        i1       = b;
        cin      = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[11];
        logic [7:0] es;
        logic       ec;
        logic       eo;
        logic [7:0] m_sum;
        logic       m_carry;
        logic       m_ovf;

        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        i0       = '0;
        i1       = '0;
        cin      = 1'b0;

        tbl[0]  = '{8'h1D, 8'h05, 1'b0, 8'h22, 1'b0, 1'b0};
        tbl[1]  = '{8'h33, 8'h5C, 1'b0, 8'h8F, 1'b0, 1'b1};
        tbl[2]  = '{8'h11, 8'h1C, 1'b0, 8'h2D, 1'b0, 1'b0};
        tbl[3]  = '{8'hBF, 8'h02, 1'b0, 8'hC1, 1'b0, 1'b0};
        tbl[4]  = '{8'hC8, 8'h5F, 1'b0, 8'h27, 1'b1, 1'b0};
        tbl[5]  = '{8'h4E, 8'hFF, 1'b0, 8'h4D, 1'b1, 1'b0};
        tbl[6]  = '{8'h31, 8'h19, 1'b0, 8'h4A, 1'b0, 1'b0};
        tbl[7]  = '{8'h2B, 8'h3B, 1'b0, 8'h66, 1'b0, 1'b0};
        tbl[8]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[10] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset state, held across edges with in_valid asserted.
        #2;
        check("reset_async", 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 8'h55, 1'b1);
        check("reset_dominates", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Directed table, each vector clocked in and checked one edge later.
        for (int k = 0; k < 11; k++) begin
            step(1'b1, tbl[k].a, tbl[k].b, tbl[k].ci);
            check($sformatf("vec%0d_%h_%h", k, tbl[k].a, tbl[k].b),
                  tbl[k].es, tbl[k].ec, 1'b1, tbl[k].eo);
        end

        // Back-to-back stream: one result per edge, out_valid stays high.
        step(1'b1, 8'hC8, 8'h5F, 1'b0);
        check("stream0", 8'h27, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h33, 8'h5C, 1'b0);
        check("stream1", 8'h8F, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h80, 8'h80, 1'b1);
        check("stream2", 8'h01, 1'b1, 1'b1, 1'b1);

        // Drop in_valid: result holds, out_valid falls.
        step(1'b0, 8'h12, 8'h34, 1'b0);
        check("hold1", 8'h01, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'hFF, 8'hFF, 1'b1);
        check("hold2", 8'h01, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset between edges with a result in flight.
        step(1'b1, 8'h4E, 8'hFF, 1'b0);
        check("pre_reset", 8'h4D, 1'b1, 1'b1, 1'b0);
        i0 = 8'h7F;
        i1 = 8'h01;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_midcycle", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_edge", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("reset_released", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h7F, 8'h01, 1'b0);
        check("post_reset_first", 8'h80, 1'b0, 1'b1, 1'b1);

        // Randomized vectors with random in_valid against the reference model.
        m_sum   = 8'h80;
        m_carry = 1'b0;
        m_ovf   = 1'b1;
        for (int k = 0; k < 12000; k++) begin
            logic       v;
            logic [7:0] a;
            logic [7:0] b;
            logic       ci;
            v  = ($urandom_range(0, 3) != 0);
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom);
            if (k % 97 == 0) begin
                a = 8'hFF;
                b = 8'hFF;
            end
            step(v, a, b, ci);
            if (v) begin
                model(a, b, ci, es, ec, eo);
                m_sum   = es;
                m_carry = ec;
                m_ovf   = eo;
            end
            check($sformatf("rand%0d", k), m_sum, m_carry, v, m_ovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
